// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neural-network layer control path:
// FSM state encoding and the index-width helper.
package nn_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_READ  = 3'd2;
    localparam state_t S_CALC  = 3'd3;
    localparam state_t S_ACT   = 3'd4;
    localparam state_t S_WRITE = 3'd5;
    localparam state_t S_DONE  = 3'd6;

    // Width of an index addressing n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/layer_controller_index_counter.sv
// Saturating index counter used for the input offset and the neuron index.
// init clears the index and wins over inc; last flags the terminal count MAX-1.
module index_counter
    import nn_ctrl_pkg::*;
#(
    parameter int MAX = 2,
    parameter int W   = idx_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         last
);

    localparam logic [W-1:0] LAST_VAL = W'(MAX - 1);

    assign last = (value == LAST_VAL);

    // Index register: cleared by reset or init, advanced by inc, held at the terminal count.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst) begin
            value <= '0;
        end else if (init) begin
            value <= '0;
        end else if (inc && !last) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/layer_controller.sv
// Control FSM for one fully-connected layer: sequences N_NEURONS neurons over
// N_INPUTS inputs each and drives the MAC datapath strobes, with abort and a
// ready/ack result handshake.
module layer_controller
    import nn_ctrl_pkg::*;
#(
    parameter int N_INPUTS  = 10,
    parameter int N_NEURONS = 4,
    parameter int IW        = idx_w(N_INPUTS),
    parameter int NW        = idx_w(N_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          ack,
    output logic [IW-1:0] offset,
    output logic [NW-1:0] neuron,
    output logic          clr,
    output logic          ld_bias,
    output logic          read,
    output logic          ld,
    output logic          act,
    output logic          wr,
    output logic          busy,
    output logic          ready
);

    state_t state;
    state_t next_state;

    logic off_last;
    logic neu_last;
    logic off_init;
    logic off_inc;
    logic neu_init;
    logic neu_inc;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: abort overrides the normal sequence everywhere except IDLE.
    always_comb begin
        // NOTE: default assignment first so no path through the block can infer a latch.
        next_state = state;
        if (abort && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  next_state = start ? S_CLEAR : S_IDLE;
                S_CLEAR: next_state = S_READ;
                S_READ:  next_state = S_CALC;
                S_CALC:  next_state = off_last ? S_ACT : S_READ;
                S_ACT:   next_state = S_WRITE;
                S_WRITE: next_state = neu_last ? S_DONE : S_CLEAR;
                S_DONE:  next_state = ack ? S_IDLE : S_DONE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Index sequencing: offset restarts for every neuron, both indices clear on the way back to IDLE.
    assign off_init = (next_state == S_IDLE) || ((state == S_WRITE) && (next_state == S_CLEAR));
    assign off_inc  = (state == S_CALC) && (next_state == S_READ);
    assign neu_init = (next_state == S_IDLE);
    assign neu_inc  = (state == S_WRITE) && (next_state == S_CLEAR);

    index_counter #(
        .MAX (N_INPUTS),
        .W   (IW)
    ) u_offset_cnt (
        .clk   (clk),
        .rst   (rst),
        .init  (off_init),
        .inc   (off_inc),
        .value (offset),
        .last  (off_last)
    );

    index_counter #(
        .MAX (N_NEURONS),
        .W   (NW)
    ) u_neuron_cnt (
        .clk   (clk),
        .rst   (rst),
        .init  (neu_init),
        .inc   (neu_inc),
        .value (neuron),
        .last  (neu_last)
    );

    // Moore output decode: each state raises only its own datapath strobe.
    always_comb begin
        clr     = 1'b0;
        ld_bias = 1'b0;
        read    = 1'b0;
        ld      = 1'b0;
        act     = 1'b0;
        wr      = 1'b0;
        ready   = 1'b0;
        busy    = (state != S_IDLE);
        case (state)
            S_CLEAR: begin
                clr     = 1'b1;
                ld_bias = 1'b1;
            end
            S_READ:  read  = 1'b1;
            S_CALC:  ld    = 1'b1;
            S_ACT:   act   = 1'b1;
            S_WRITE: wr    = 1'b1;
            S_DONE:  ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_layer_controller.sv
// Self-checking bench for layer_controller: a table of single-cycle vectors on a
// 1x1 instance, and a cycle-accurate scoreboard on a default 10x4 instance.
module tb_layer_controller;

    localparam int BN_IN  = 10;
    localparam int BN_NEU = 4;
    localparam int PER    = 2 * BN_IN + 3;   // cycles per neuron
    localparam int TOTAL  = BN_NEU * PER;    // start edge to ready

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default-size instance
    logic       b_start, b_abort, b_ack;
    logic [3:0] b_offset;
    logic [1:0] b_neuron;
    logic       b_clr, b_ld_bias, b_read, b_ld, b_act, b_wr, b_busy, b_ready;
    logic [7:0] b_strb;

    // 1x1 instance
    logic       s_start, s_abort, s_ack;
    logic [0:0] s_offset;
    logic [0:0] s_neuron;
    logic       s_clr, s_ld_bias, s_read, s_ld, s_act, s_wr, s_busy, s_ready;
    logic [7:0] s_strb;

    assign b_strb = {b_busy, b_clr, b_ld_bias, b_read, b_ld, b_act, b_wr, b_ready};
    assign s_strb = {s_busy, s_clr, s_ld_bias, s_read, s_ld, s_act, s_wr, s_ready};

    layer_controller dut_big (
        .clk     (clk),
        .rst     (rst),
        .start   (b_start),
        .abort   (b_abort),
        .ack     (b_ack),
        .offset  (b_offset),
        .neuron  (b_neuron),
        .clr     (b_clr),
        .ld_bias (b_ld_bias),
        .read    (b_read),
        .ld      (b_ld),
        .act     (b_act),
        .wr      (b_wr),
        .busy    (b_busy),
        .ready   (b_ready)
    );

    layer_controller #(
        .N_INPUTS  (1),
        .N_NEURONS (1)
    ) dut_small (
        .clk     (clk),
        .rst     (rst),
        .start   (s_start),
        .abort   (s_abort),
        .ack     (s_ack),
        .offset  (s_offset),
        .neuron  (s_neuron),
        .clr     (s_clr),
        .ld_bias (s_ld_bias),
        .read    (s_read),
        .ld      (s_ld),
        .act     (s_act),
        .wr      (s_wr),
        .busy    (s_busy),
        .ready   (s_ready)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) tick();
    endtask

    // ------------------------------------------------------------------
    // Scoreboard for the default instance
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned cyc;
        int          k;
        logic [7:0]  strb;    // {busy,clr,ld_bias,read,ld,act,wr,ready}
        logic [3:0]  off;
        logic [1:0]  neu;
        bit          idx_ok;  // indices are defined for this cycle
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Expected outputs k cycles after the start edge, from the per-neuron schedule.
    function automatic exp_t model(input int k, input int unsigned c0);
        exp_t e;
        int   n;
        int   p;
        e.cyc    = c0 + k;
        e.k      = k;
        e.off    = '0;
        e.neu    = '0;
        e.idx_ok = 1'b1;
        if (k >= TOTAL) begin
            e.strb   = 8'b1000_0001;
            e.idx_ok = 1'b0;
        end else begin
            n     = k / PER;
            p     = k % PER;
            e.neu = 2'(n);
            if (p == 0) begin
                e.strb = 8'b1110_0000;
            end else if (p == PER - 2) begin
                e.strb = 8'b1000_0100;
                e.off  = 4'(BN_IN - 1);
            end else if (p == PER - 1) begin
                e.strb = 8'b1000_0010;
                e.off  = 4'(BN_IN - 1);
            end else if (p % 2 == 1) begin
                e.strb = 8'b1001_0000;
                e.off  = 4'((p - 1) / 2);
            end else begin
                e.strb = 8'b1000_1000;
                e.off  = 4'((p - 2) / 2);
            end
        end
        return e;
    endfunction

    // Called right after a clock edge while driving start: the start edge is the next one.
    task automatic push_layer(input int n_rec);
        int unsigned c0;
        c0 = cyc + 1;
        for (int k = 0; k < n_rec; k++) sb.push_back(model(k, c0));
    endtask

    int ld_cnt = 0;
    int wr_cnt = 0;

    always @(negedge clk) begin
        if (b_ld) ld_cnt <= ld_cnt + 1;
        if (b_wr) wr_cnt <= wr_cnt + 1;
        if ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            mon_e = sb.pop_front();
            check($sformatf("sb_cycle k=%0d", mon_e.k), cyc, mon_e.cyc);
            check($sformatf("sb_strobes k=%0d", mon_e.k), b_strb, mon_e.strb);
            if (mon_e.idx_ok) begin
                check($sformatf("sb_offset k=%0d", mon_e.k), b_offset, mon_e.off);
                check($sformatf("sb_neuron k=%0d", mon_e.k), b_neuron, mon_e.neu);
            end
        end
    end

    task automatic wait_ready(input string name, input int unsigned c0, input int expected);
        int el;
        el = -1;
        for (int i = 0; i < 300; i++) begin
            if (b_ready) begin
                el = int'(cyc - c0);
                break;
            end
            tick();
        end
        check(name, el, expected);
    endtask

    // ------------------------------------------------------------------
    // 1x1 vector table: inputs for one edge, outputs expected after it
    // ------------------------------------------------------------------
    typedef struct {
        logic       start;
        logic       abort;
        logic       ack;
        logic [7:0] strb;
    } vec_t;

    vec_t tbl[15];

    int unsigned c0;
    int          ld0, wr0, hits;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'b0000_0000};  // idle stays idle
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'b0000_0000};  // abort in IDLE is a no-op
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'b0000_0000};  // ack in IDLE ignored
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'b1110_0000};  // start beats abort -> CLEAR
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'b1001_0000};  // READ, start ignored
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'b1000_1000};  // CALC, ack ignored
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0100};  // ACT, no input loop
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'b1000_0010};  // WRITE
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'b1000_0001};  // DONE at start+5
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'b1000_0001};  // start in DONE ignored
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'b0000_0000};  // abort+ack in DONE -> IDLE
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'b1110_0000};  // restart
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'b1001_0000};  // READ
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'b0000_0000};  // abort -> IDLE
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000};  // no ready after abort

        rst     = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_ack = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_ack = 1'b0;
        tick();
        tick();
        check("reset_big",   {22'd0, b_strb, b_offset, b_neuron}, 32'd0);
        check("reset_small", {22'd0, s_strb, s_offset, s_neuron}, 32'd0);
        rst = 1'b1;
        tick();

        // ---------------- 1x1 table ----------------
        for (int i = 0; i < 15; i++) begin
            s_start = tbl[i].start;
            s_abort = tbl[i].abort;
            s_ack   = tbl[i].ack;
            tick();
            check($sformatf("small_vec%0d", i), {22'd0, s_strb, s_offset, s_neuron},
                  {22'd0, tbl[i].strb, 2'b00});
        end
        s_start = 1'b0; s_abort = 1'b0; s_ack = 1'b0;

        // ---------------- A: nominal layer, ack 2 cycles after ready ----------------
        ld0 = ld_cnt;
        wr0 = wr_cnt;
        c0  = cyc + 1;
        b_start = 1'b1;
        push_layer(TOTAL + 3);
        tick();
        b_start = 1'b0;
        wait_ready("A_ready_latency", c0, TOTAL);
        tick();
        tick();
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("A_ready_fall", {b_busy, b_ready}, 2'b00);
        check("A_ld_pulses", ld_cnt - ld0, BN_NEU * BN_IN);
        check("A_wr_pulses", wr_cnt - wr0, BN_NEU);
        check("A_sb_drained", sb.size(), 0);

        // ---------------- B: spurious start/ack while busy, DONE held 20 cycles ----------------
        tick();
        c0 = cyc + 1;
        b_start = 1'b1;
        push_layer(TOTAL + 21);
        tick();
        b_start = 1'b0;
        wait_until(c0 + 10);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_until(c0 + 30);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        wait_until(c0 + 50);
        b_start = 1'b1;
        b_ack   = 1'b1;
        tick();
        b_start = 1'b0;
        b_ack   = 1'b0;
        wait_until(c0 + TOTAL + 20);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("B_ready_fall", {b_busy, b_ready}, 2'b00);
        check("B_sb_drained", sb.size(), 0);

        // ---------------- C: abort in CALC, offset 5, neuron 2 ----------------
        tick();
        c0 = cyc + 1;
        b_start = 1'b1;
        push_layer(2 * PER + 13);
        tick();
        b_start = 1'b0;
        wait_until(c0 + 2 * PER + 12);
        check("C_pre_abort", {22'd0, b_strb, b_offset, b_neuron}, {22'd0, 8'b1000_1000, 4'd5, 2'd2});
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        check("C_post_abort", {22'd0, b_strb, b_offset, b_neuron}, 32'd0);
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (b_wr || b_ready || b_busy) hits++;
        end
        check("C_quiet_after_abort", hits, 0);
        check("C_sb_drained", sb.size(), 0);

        // ---------------- D: reset pulse mid-layer in READ, then a full run ----------------
        c0 = cyc + 1;
        b_start = 1'b1;
        push_layer(4);
        tick();
        b_start = 1'b0;
        wait_until(c0 + 3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("D_reset_outputs", {22'd0, b_strb, b_offset, b_neuron}, 32'd0);
        tick();
        ld0 = ld_cnt;
        c0  = cyc + 1;
        b_start = 1'b1;
        push_layer(TOTAL + 3);
        tick();
        b_start = 1'b0;
        wait_ready("D_ready_latency", c0, TOTAL);
        tick();
        tick();
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        check("D_ready_fall", {b_busy, b_ready}, 2'b00);
        check("D_ld_pulses", ld_cnt - ld0, BN_NEU * BN_IN);
        check("D_sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
